// File: rtl/axi2apb_cmd_burst_pkg.sv
// Shared definitions for the AXI-to-APB command stage: burst encodings,
// command FIFO entry sizing and the maximum legal beat size.
package axi2apb_cmd_burst_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_t;

  localparam int DEF_DATA_BITS = 32;

  function automatic int max_size(input int data_bits);
    return $clog2(data_bits / 8);
  endfunction

  localparam int MAX_SIZE = max_size(DEF_DATA_BITS);

  // Entry packs {id, addr, len, size[3], burst[2], err, read}
  function automatic int entry_bits(input int id_bits, input int addr_bits, input int len_bits);
    return id_bits + addr_bits + len_bits + 3 + 2 + 1 + 1;
  endfunction

endpackage

// File: rtl/axi2apb_cmd_burst_if.sv
// AXI command channels plus the beat hand-off to the APB sequencer.
interface axi2apb_cmd_burst_if #(
  parameter int ID_BITS   = 4,
  parameter int ADDR_BITS = 32,
  parameter int LEN_BITS  = 4
);
  logic [ID_BITS-1:0]   AWID,    ARID;
  logic [ADDR_BITS-1:0] AWADDR,  ARADDR;
  logic [LEN_BITS-1:0]  AWLEN,   ARLEN;
  logic [2:0]           AWSIZE,  ARSIZE;
  logic [1:0]           AWBURST, ARBURST;
  logic                 AWVALID, ARVALID;
  logic                 AWREADY, ARREADY;
  logic                 finish_wr, finish_rd;
  logic                 cmd_empty, cmd_read, cmd_err, cmd_last;
  logic [ID_BITS-1:0]   cmd_id;
  logic [ADDR_BITS-1:0] cmd_addr;

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  finish_wr, finish_rd,
    output AWREADY, ARREADY,
    output cmd_empty, cmd_read, cmd_id, cmd_addr, cmd_err, cmd_last
  );

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output finish_wr, finish_rd,
    input  AWREADY, ARREADY,
    input  cmd_empty, cmd_read, cmd_id, cmd_addr, cmd_err, cmd_last
  );
endinterface

// File: rtl/axi2apb_beat_gen.sv
// Walks the FIFO head command beat by beat: counter, next address, last flag.
// AXI2APB_WRAP_EN builds WRAP addressing; otherwise WRAP falls back to FIXED.
module axi2apb_beat_gen
  import axi2apb_cmd_burst_pkg::*;
#(
  parameter int ADDR_BITS = 32,
  parameter int LEN_BITS  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 empty,
  input  logic                 read,
  input  logic                 finish_wr,
  input  logic                 finish_rd,
  input  logic [ADDR_BITS-1:0] start_addr,
  input  logic [LEN_BITS-1:0]  len,
  input  logic [2:0]           size,
  input  logic [1:0]           burst,
  output logic [ADDR_BITS-1:0] beat_addr,
  output logic                 beat_last,
  output logic                 entry_pop
);
  logic [LEN_BITS-1:0]  cnt;
  logic [ADDR_BITS-1:0] cur_addr, next_addr, incr;
  logic                 beat_pop;
`ifdef AXI2APB_WRAP_EN
  logic [ADDR_BITS-1:0] wrap_mask;
  assign wrap_mask = ((ADDR_BITS'(len) + 1'b1) << size) - 1'b1;
`endif

  // Beat 0 reads straight from the FIFO head so a fresh entry needs no load cycle
  assign beat_addr = (cnt == '0) ? start_addr : cur_addr;
  assign beat_last = (cnt == len);
  assign beat_pop  = ~empty & (read ? finish_rd : finish_wr);
  assign entry_pop = beat_pop & beat_last;
  assign incr      = ADDR_BITS'(1) << size;

  always_comb begin
    next_addr = beat_addr;
    case (burst_t'(burst))
      BURST_INCR: next_addr = beat_addr + incr;
`ifdef AXI2APB_WRAP_EN
      BURST_WRAP: next_addr = (beat_addr & ~wrap_mask) | ((beat_addr + incr) & wrap_mask);
`endif
      default:    next_addr = beat_addr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      cur_addr <= '0;
    end else if (beat_pop) begin
      if (beat_last) begin
        cnt <= '0;
      end else begin
        cnt      <= cnt + 1'b1;
        cur_addr <= next_addr;
      end
    end
  end
endmodule

// File: rtl/prgen_fifo.sv
// Plain synchronous FIFO; head entry is visible combinationally on dout.
module prgen_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/axi2apb_cmd_burst.sv
// AXI-to-APB command stage: AW/AR round-robin, command checking, queueing and
// per-beat expansion. AXI2APB_WRAP_EN enables WRAP bursts (else they are errors).
module axi2apb_cmd_burst
  import axi2apb_cmd_burst_pkg::*;
#(
  parameter int ID_BITS   = 4,
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int CMD_DEPTH = 4,
  parameter int LEN_BITS  = 4
) (
  input logic               clk,
  input logic               reset,
  axi2apb_cmd_burst_if.slave bus
);
  localparam int MAX_SZ = max_size(DATA_BITS);
  localparam int EW     = entry_bits(ID_BITS, ADDR_BITS, LEN_BITS);
  localparam int SPAN_W = LEN_BITS + 14;

  logic                 prio_read, sel_read, push, full, empty, fifo_pop;
  logic [ID_BITS-1:0]   in_id, h_id;
  logic [ADDR_BITS-1:0] in_addr, h_addr, align_mask, beat_addr;
  logic [LEN_BITS-1:0]  in_len, h_len;
  logic [2:0]           in_size, h_size;
  burst_t               in_burst;
  logic [1:0]           h_burst;
  logic                 in_err, h_err, h_read, beat_last;
  logic                 misaligned, cross_4k, wrap_bad;
  logic [SPAN_W-1:0]    span_end;
  logic [EW-1:0]        din, dout;

  always_comb begin
    if (bus.ARVALID && bus.AWVALID) sel_read = prio_read;
    else if (bus.ARVALID)           sel_read = 1'b1;
    else if (bus.AWVALID)           sel_read = 1'b0;
    else                            sel_read = prio_read;
  end

  assign bus.ARREADY = ~reset & ~full & sel_read;
  assign bus.AWREADY = ~reset & ~full & ~sel_read;
  assign push = (bus.ARVALID & bus.ARREADY) | (bus.AWVALID & bus.AWREADY);

  always_ff @(posedge clk) begin
    if (reset)     prio_read <= 1'b1;
    else if (push) prio_read <= ~prio_read;
  end

  assign in_id    = sel_read ? bus.ARID    : bus.AWID;
  assign in_addr  = sel_read ? bus.ARADDR  : bus.AWADDR;
  assign in_len   = sel_read ? bus.ARLEN   : bus.AWLEN;
  assign in_size  = sel_read ? bus.ARSIZE  : bus.AWSIZE;
  assign in_burst = burst_t'(sel_read ? bus.ARBURST : bus.AWBURST);

  assign align_mask = (ADDR_BITS'(1) << in_size) - 1'b1;
  assign misaligned = |(in_addr & align_mask);
  assign span_end   = SPAN_W'(in_addr[11:0]) + ((SPAN_W'(in_len) + 1'b1) << in_size);
  assign cross_4k   = span_end > SPAN_W'(4096);
`ifdef AXI2APB_WRAP_EN
  assign wrap_bad = !(int'(in_len) == 1 || int'(in_len) == 3 ||
                      int'(in_len) == 7 || int'(in_len) == 15);
`else
  assign wrap_bad = 1'b1;
`endif

  assign in_err = (in_size > 3'(MAX_SZ)) || (in_burst == BURST_RSVD) || misaligned ||
                  ((in_burst == BURST_INCR) && cross_4k) ||
                  ((in_burst == BURST_WRAP) && wrap_bad);

  assign din = {in_id, in_addr, in_len, in_size, in_burst, in_err, sel_read};
  assign {h_id, h_addr, h_len, h_size, h_burst, h_err, h_read} = dout;

  prgen_fifo #(.WIDTH(EW), .DEPTH(CMD_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(fifo_pop),
    .din(din), .dout(dout), .empty(empty), .full(full)
  );

  axi2apb_beat_gen #(.ADDR_BITS(ADDR_BITS), .LEN_BITS(LEN_BITS)) u_beat_gen (
    .clk(clk), .reset(reset), .empty(empty), .read(h_read),
    .finish_wr(bus.finish_wr), .finish_rd(bus.finish_rd),
    .start_addr(h_addr), .len(h_len), .size(h_size), .burst(h_burst),
    .beat_addr(beat_addr), .beat_last(beat_last), .entry_pop(fifo_pop)
  );

  // Idle outputs read as a neutral read beat so the sequencer sees clean values
  assign bus.cmd_empty = empty;
  assign bus.cmd_read  = empty | h_read;
  assign bus.cmd_id    = empty ? '0 : h_id;
  assign bus.cmd_addr  = empty ? '0 : beat_addr;
  assign bus.cmd_err   = ~empty & h_err;
  assign bus.cmd_last  = ~empty & beat_last;
endmodule

// File: tb/tb_axi2apb_cmd_burst.sv
// Directed bench for axi2apb_cmd_burst; WRAP expectations follow AXI2APB_WRAP_EN.
module tb_axi2apb_cmd_burst;
  import axi2apb_cmd_burst_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  axi2apb_cmd_burst_if #(.ID_BITS(4), .ADDR_BITS(32), .LEN_BITS(4)) bus ();

  axi2apb_cmd_burst #(
    .ID_BITS(4), .ADDR_BITS(32), .DATA_BITS(32), .CMD_DEPTH(4), .LEN_BITS(4)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input bit rd, input logic [3:0] id, input logic [31:0] addr,
                      input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst,
                      output int waits);
    waits = 0;
    @(negedge clk);
    if (rd) begin
      bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len;
      bus.ARSIZE = size; bus.ARBURST = burst; bus.ARVALID = 1'b1;
    end else begin
      bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len;
      bus.AWSIZE = size; bus.AWBURST = burst; bus.AWVALID = 1'b1;
    end
    #1;
    while (!(rd ? bus.ARREADY : bus.AWREADY) && waits < 40) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (waits >= 40) chk("accept_timeout", 64'(waits), 64'd0);
    @(negedge clk);
    bus.ARVALID = 1'b0;
    bus.AWVALID = 1'b0;
  endtask

  task automatic finish(input bit rd);
    if (rd) bus.finish_rd = 1'b1;
    else    bus.finish_wr = 1'b1;
    @(negedge clk);
    bus.finish_rd = 1'b0;
    bus.finish_wr = 1'b0;
  endtask

  task automatic run_beats(input string tag, input bit rd, input logic [31:0] addrs [4],
                           input int n, input bit err);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_b%0d_empty", tag, i), 64'(bus.cmd_empty), 64'd0);
      chk($sformatf("%s_b%0d_read", tag, i), 64'(bus.cmd_read), 64'(rd));
      chk($sformatf("%s_b%0d_addr", tag, i), 64'(bus.cmd_addr), 64'(addrs[i]));
      chk($sformatf("%s_b%0d_err", tag, i), 64'(bus.cmd_err), 64'(err));
      chk($sformatf("%s_b%0d_last", tag, i), 64'(bus.cmd_last), 64'(i == n - 1));
      finish(rd);
    end
    chk($sformatf("%s_done_empty", tag), 64'(bus.cmd_empty), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    bit ar_exp;
    bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0;
    bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARBURST = '0;
    bus.AWVALID = 1'b0; bus.ARVALID = 1'b0;
    bus.finish_wr = 1'b0; bus.finish_rd = 1'b0;

    // Reset state, sampled while reset is still asserted
    @(negedge clk);
    @(negedge clk);
    chk("rst_arready", 64'(bus.ARREADY), 64'd0);
    chk("rst_awready", 64'(bus.AWREADY), 64'd0);
    chk("rst_empty",   64'(bus.cmd_empty), 64'd1);
    chk("rst_read",    64'(bus.cmd_read), 64'd1);
    chk("rst_id",      64'(bus.cmd_id), 64'd0);
    chk("rst_addr",    64'(bus.cmd_addr), 64'd0);
    chk("rst_err",     64'(bus.cmd_err), 64'd0);
    chk("rst_last",    64'(bus.cmd_last), 64'd0);
    reset = 1'b0;
    #1;
    chk("idle_arready", 64'(bus.ARREADY), 64'd1);
    chk("idle_awready", 64'(bus.AWREADY), 64'd0);

    // 1: single read beat
    send(1'b1, 4'd3, 32'h100, 4'd0, 3'd2, BURST_INCR, w);
    chk("t1_arready_at_once", 64'(w), 64'd0);
    chk("t1_id", 64'(bus.cmd_id), 64'd3);
    run_beats("t1", 1'b1, '{32'h100, 32'h0, 32'h0, 32'h0}, 1, 1'b0);

    // 2: INCR write burst; a read finish must not advance a write beat
    send(1'b0, 4'd4, 32'h1000, 4'd3, 3'd2, BURST_INCR, w);
    finish(1'b1);
    chk("t2_wrong_finish_addr", 64'(bus.cmd_addr), 64'h1000);
    run_beats("t2", 1'b0, '{32'h1000, 32'h1004, 32'h1008, 32'h100C}, 4, 1'b0);

    // 3: both requesting every cycle, round robin until full
    do_reset();
    @(negedge clk);
    bus.ARID = 4'd1; bus.ARADDR = 32'h200; bus.ARLEN = 4'd0; bus.ARSIZE = 3'd2;
    bus.ARBURST = BURST_INCR; bus.ARVALID = 1'b1;
    bus.AWID = 4'd2; bus.AWADDR = 32'h300; bus.AWLEN = 4'd0; bus.AWSIZE = 3'd2;
    bus.AWBURST = BURST_INCR; bus.AWVALID = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      ar_exp = (i < 4) && (i % 2 == 0);
      chk($sformatf("t3_c%0d_arready", i), 64'(bus.ARREADY), 64'(ar_exp));
      chk($sformatf("t3_c%0d_awready", i), 64'(bus.AWREADY), 64'((i < 4) && !ar_exp));
      @(negedge clk);
    end
    chk("t3_head_read", 64'(bus.cmd_read), 64'd1);
    chk("t3_head_id",   64'(bus.cmd_id), 64'd1);
    bus.finish_rd = 1'b1;
    #1;
    chk("t3_full_pop_arready", 64'(bus.ARREADY), 64'd0);
    chk("t3_full_pop_awready", 64'(bus.AWREADY), 64'd0);
    @(negedge clk);
    bus.finish_rd = 1'b0;
    #1;
    chk("t3_after_pop_arready", 64'(bus.ARREADY), 64'd1);
    chk("t3_after_pop_awready", 64'(bus.AWREADY), 64'd0);
    bus.ARVALID = 1'b0;
    bus.AWVALID = 1'b0;
    @(negedge clk);
    chk("t3_q1_read", 64'(bus.cmd_read), 64'd0);
    chk("t3_q1_addr", 64'(bus.cmd_addr), 64'h300);
    finish(1'b0);
    chk("t3_q2_read", 64'(bus.cmd_read), 64'd1);
    chk("t3_q2_addr", 64'(bus.cmd_addr), 64'h200);
    finish(1'b1);
    chk("t3_q3_read", 64'(bus.cmd_read), 64'd0);
    chk("t3_q3_id",   64'(bus.cmd_id), 64'd2);
    finish(1'b0);
    chk("t3_drained", 64'(bus.cmd_empty), 64'd1);

    // 4: error commands keep their beat count
    send(1'b0, 4'd5, 32'h0, 4'd0, 3'd3, BURST_INCR, w);
    run_beats("t4_size", 1'b0, '{32'h0, 32'h0, 32'h0, 32'h0}, 1, 1'b1);
    send(1'b0, 4'd6, 32'hFFC, 4'd1, 3'd2, BURST_INCR, w);
    run_beats("t4_4k", 1'b0, '{32'hFFC, 32'h1000, 32'h0, 32'h0}, 2, 1'b1);
    send(1'b1, 4'd7, 32'h102, 4'd0, 3'd2, BURST_INCR, w);
    run_beats("t4_align", 1'b1, '{32'h102, 32'h0, 32'h0, 32'h0}, 1, 1'b1);
    send(1'b0, 4'd8, 32'hFF8, 4'd1, 3'd2, BURST_INCR, w);
    run_beats("t4_4k_edge", 1'b0, '{32'hFF8, 32'hFFC, 32'h0, 32'h0}, 2, 1'b0);
    send(1'b1, 4'd9, 32'h40, 4'd1, 3'd2, BURST_RSVD, w);
    run_beats("t4_rsvd", 1'b1, '{32'h40, 32'h40, 32'h0, 32'h0}, 2, 1'b1);

    // 5: WRAP burst
    send(1'b1, 4'd10, 32'h38, 4'd3, 3'd2, BURST_WRAP, w);
`ifdef AXI2APB_WRAP_EN
    run_beats("t5_wrap", 1'b1, '{32'h38, 32'h3C, 32'h30, 32'h34}, 4, 1'b0);
`else
    run_beats("t5_wrap", 1'b1, '{32'h38, 32'h38, 32'h38, 32'h38}, 4, 1'b1);
`endif

    // 6: reset in the middle of a burst with another command queued
    send(1'b0, 4'd11, 32'h2000, 4'd3, 3'd2, BURST_INCR, w);
    send(1'b1, 4'd12, 32'h500, 4'd0, 3'd2, BURST_INCR, w);
    finish(1'b0);
    finish(1'b0);
    chk("t6_beat2_addr", 64'(bus.cmd_addr), 64'h2008);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_empty",   64'(bus.cmd_empty), 64'd1);
    chk("t6_rst_arready", 64'(bus.ARREADY), 64'd0);
    chk("t6_rst_awready", 64'(bus.AWREADY), 64'd0);
    reset = 1'b0;
    send(1'b1, 4'd7, 32'h400, 4'd1, 3'd2, BURST_INCR, w);
    chk("t6_new_id", 64'(bus.cmd_id), 64'd7);
    run_beats("t6_new", 1'b1, '{32'h400, 32'h404, 32'h0, 32'h0}, 2, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
